// File: rtl/csr_commit_pkg.sv
// Shared definitions for the CSR retire path: exception codes,
// the CSR address field and the E2 stage bundle.
package csr_commit_pkg;

    localparam int EXCEPTION_W = 6;

    localparam logic [EXCEPTION_W-1:0] EXCEPTION_ILLEGAL_INSTRUCTION = 6'h12;
    localparam logic [EXCEPTION_W-1:0] EXCEPTION_BREAKPOINT          = 6'h13;
    localparam logic [EXCEPTION_W-1:0] EXCEPTION_ECALL               = 6'h18;
    localparam logic [EXCEPTION_W-1:0] EXCEPTION_INTERRUPT           = 6'h20;
    localparam logic [EXCEPTION_W-1:0] EXCEPTION_ERET_U              = 6'h30;
    localparam logic [EXCEPTION_W-1:0] EXCEPTION_FENCE               = 6'h3f;

    localparam int CSR_ADDR_HI = 31;
    localparam int CSR_ADDR_LO = 20;

    typedef struct packed {
        logic                   valid;
        logic [31:0]            pc;
        logic [11:0]            waddr;
        logic [31:0]            value;
        logic                   write;
        logic [31:0]            wdata;
        logic [EXCEPTION_W-1:0] exc;
    } e2_t;

endpackage

// File: rtl/csr_commit_exc_sel.sv
// E2 exception priority resolver: carried E1 code, then LSU fault,
// then a pending interrupt; produces the retired code and tval.
module csr_commit_exc_sel #(
    parameter int SUPPORT_LSU_FAULT = 1,
    parameter int EXCEPTION_W       = 6
) (
    input  logic                   valid,
    input  logic                   stall,
    input  logic [EXCEPTION_W-1:0] carried,
    input  logic [31:0]            pc,
    input  logic [31:0]            value,
    input  logic                   lsu_fault,
    input  logic [EXCEPTION_W-1:0] lsu_code,
    input  logic [31:0]            lsu_addr,
    input  logic                   take_interrupt,
    output logic [EXCEPTION_W-1:0] code,
    output logic [31:0]            tval
);
    import csr_commit_pkg::*;

    logic fault;

    assign fault = (SUPPORT_LSU_FAULT != 0) && lsu_fault;

    always_comb begin
        code = '0;
        tval = '0;
        if (!valid) begin
            code = '0;
        end else if (carried != '0) begin
            code = carried;
            if (carried == EXCEPTION_ILLEGAL_INSTRUCTION)
                tval = value;
            else if (carried == EXCEPTION_BREAKPOINT)
                tval = pc;
        end else if (fault) begin
            code = lsu_code;
            tval = lsu_addr;
        end else if (take_interrupt && !stall) begin
            code = EXCEPTION_INTERRUPT;
        end
    end

endmodule

// File: rtl/csr_commit.sv
// CSR retire path: E2 and WB alignment, trap squash, interrupt inhibit.
// Optional retire counter enabled by CSR_COMMIT_RETIRE_CNT_EN.
module csr_commit #(
    parameter int SUPPORT_LSU_FAULT = 1,
    parameter int EXCEPTION_W       = 6
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   e1_valid_i,
    input  logic [31:0]            e1_pc_i,
    input  logic [31:0]            e1_opcode_i,
    input  logic [31:0]            csr_result_e1_value_i,
    input  logic                   csr_result_e1_write_i,
    input  logic [31:0]            csr_result_e1_wdata_i,
    input  logic [EXCEPTION_W-1:0] csr_result_e1_exception_i,
    input  logic                   lsu_fault_i,
    input  logic [EXCEPTION_W-1:0] lsu_fault_code_i,
    input  logic [31:0]            lsu_fault_addr_i,
    input  logic                   take_interrupt_i,
    input  logic                   stall_i,
    output logic                   csr_writeback_write_o,
    output logic [11:0]            csr_writeback_waddr_o,
    output logic [31:0]            csr_writeback_wdata_o,
    output logic [EXCEPTION_W-1:0] csr_writeback_exception_o,
    output logic [31:0]            csr_writeback_exception_pc_o,
    output logic [31:0]            csr_writeback_exception_addr_o,
    output logic                   interrupt_inhibit_o,
    output logic                   squash_o
`ifdef CSR_COMMIT_RETIRE_CNT_EN
    ,
    output logic [63:0]            retire_count_o
`endif
);
    import csr_commit_pkg::*;

    e2_t                    e2;
    logic [EXCEPTION_W-1:0] exc_code;
    logic [31:0]            exc_tval;
    logic                   squash;
    logic                   advance;
    logic                   wb_write;
    logic                   unused_opcode;

    assign unused_opcode = ^e1_opcode_i[CSR_ADDR_LO-1:0];

    assign squash   = csr_writeback_exception_o != '0;
    assign squash_o = squash;
    assign advance  = e2.valid & ~stall_i & ~squash;
    assign wb_write = e2.write & (exc_code == '0);

    csr_commit_exc_sel #(
        .SUPPORT_LSU_FAULT(SUPPORT_LSU_FAULT),
        .EXCEPTION_W      (EXCEPTION_W)
    ) u_exc_sel (
        .valid         (e2.valid),
        .stall         (stall_i),
        .carried       (e2.exc),
        .pc            (e2.pc),
        .value         (e2.value),
        .lsu_fault     (lsu_fault_i),
        .lsu_code      (lsu_fault_code_i),
        .lsu_addr      (lsu_fault_addr_i),
        .take_interrupt(take_interrupt_i),
        .code          (exc_code),
        .tval          (exc_tval)
    );

    // A retiring trap kills E2 even while stalled and drops the E1 offer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            e2 <= '0;
        end else if (squash) begin
            e2 <= '0;
        end else if (!stall_i) begin
            if (e1_valid_i)
                e2 <= '{valid: 1'b1,
                        pc:    e1_pc_i,
                        waddr: e1_opcode_i[CSR_ADDR_HI:CSR_ADDR_LO],
                        value: csr_result_e1_value_i,
                        write: csr_result_e1_write_i,
                        wdata: csr_result_e1_wdata_i,
                        exc:   csr_result_e1_exception_i};
            else
                e2 <= '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            csr_writeback_write_o          <= 1'b0;
            csr_writeback_waddr_o          <= '0;
            csr_writeback_wdata_o          <= '0;
            csr_writeback_exception_o      <= '0;
            csr_writeback_exception_pc_o   <= '0;
            csr_writeback_exception_addr_o <= '0;
        end else if (advance) begin
            csr_writeback_write_o          <= wb_write;
            csr_writeback_waddr_o          <= wb_write ? e2.waddr : 12'h0;
            csr_writeback_wdata_o          <= wb_write ? e2.wdata : 32'h0;
            csr_writeback_exception_o      <= exc_code;
            csr_writeback_exception_pc_o   <= (exc_code != '0) ? e2.pc : 32'h0;
            csr_writeback_exception_addr_o <= exc_tval;
        end else begin
            csr_writeback_write_o          <= 1'b0;
            csr_writeback_waddr_o          <= '0;
            csr_writeback_wdata_o          <= '0;
            csr_writeback_exception_o      <= '0;
            csr_writeback_exception_pc_o   <= '0;
            csr_writeback_exception_addr_o <= '0;
        end
    end

    // Holds off interrupts while a CSR update or trap is still in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            interrupt_inhibit_o <= 1'b0;
        else
            interrupt_inhibit_o <= (e2.valid & e2.write)
                                 | (e2.valid & (e2.exc != '0))
                                 | csr_writeback_write_o
                                 | squash
                                 | (e1_valid_i & (csr_result_e1_exception_i != '0));
    end

`ifdef CSR_COMMIT_RETIRE_CNT_EN
    logic wb_valid;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_valid       <= 1'b0;
            retire_count_o <= '0;
        end else begin
            wb_valid <= advance;
            if (wb_valid && !squash)
                retire_count_o <= retire_count_o + 64'd1;
        end
    end
`else
    // instret is counted outside this block
`endif

endmodule

// File: tb/tb_csr_commit.sv
// Table-driven bench for csr_commit with a retire scoreboard.
// Hand sequences cover squash, stall and reset corner cases.
module tb_csr_commit;
    import csr_commit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        e1_valid;
    logic [31:0] e1_pc;
    logic [31:0] e1_opcode;
    logic [31:0] e1_value;
    logic        e1_write;
    logic [31:0] e1_wdata;
    logic [5:0]  e1_exc;
    logic        lsu_fault;
    logic [5:0]  lsu_code;
    logic [31:0] lsu_addr;
    logic        take_int;
    logic        stall;
    logic        wb_write;
    logic [11:0] wb_waddr;
    logic [31:0] wb_wdata;
    logic [5:0]  wb_exc;
    logic [31:0] wb_pc;
    logic [31:0] wb_addr;
    logic        inhibit;
    logic        squash;
`ifdef CSR_COMMIT_RETIRE_CNT_EN
    logic [63:0] retire_count;
`endif

    always #5 clk = ~clk;

    csr_commit dut (
        .clk_i                         (clk),
        .rst_ni                        (rst_n),
        .e1_valid_i                    (e1_valid),
        .e1_pc_i                       (e1_pc),
        .e1_opcode_i                   (e1_opcode),
        .csr_result_e1_value_i         (e1_value),
        .csr_result_e1_write_i         (e1_write),
        .csr_result_e1_wdata_i         (e1_wdata),
        .csr_result_e1_exception_i     (e1_exc),
        .lsu_fault_i                   (lsu_fault),
        .lsu_fault_code_i              (lsu_code),
        .lsu_fault_addr_i              (lsu_addr),
        .take_interrupt_i              (take_int),
        .stall_i                       (stall),
        .csr_writeback_write_o         (wb_write),
        .csr_writeback_waddr_o         (wb_waddr),
        .csr_writeback_wdata_o         (wb_wdata),
        .csr_writeback_exception_o     (wb_exc),
        .csr_writeback_exception_pc_o  (wb_pc),
        .csr_writeback_exception_addr_o(wb_addr),
        .interrupt_inhibit_o           (inhibit),
        .squash_o                      (squash)
`ifdef CSR_COMMIT_RETIRE_CNT_EN
        ,
        .retire_count_o                (retire_count)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] opcode;
        logic [31:0] value;
        logic        write;
        logic [31:0] wdata;
        logic [5:0]  exc;
        logic        lsu;
        logic [5:0]  lsu_code;
        logic [31:0] lsu_addr;
        logic        intr;
        logic        exp_write;
        logic [11:0] exp_waddr;
        logic [31:0] exp_wdata;
        logic [5:0]  exp_exc;
        logic [31:0] exp_pc;
        logic [31:0] exp_addr;
    } vec_t;

    typedef struct {
        logic        write;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic [5:0]  exc;
        logic [31:0] pc;
        logic [31:0] addr;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[11];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Scoreboard: every retirement with a write or trap must be expected.
    always @(negedge clk) begin
        if (rst_n && (wb_write || wb_exc != 6'h0)) begin
            if (sb.size() == 0) begin
                check("unexpected_retire", {wb_write, wb_exc, wb_waddr}, 64'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("write", wb_write, e.write);
                check("waddr", wb_waddr, e.waddr);
                check("wdata", wb_wdata, e.wdata);
                check("exception", wb_exc, e.exc);
                if (e.exc != 6'h0)
                    check("exception_pc", wb_pc, e.pc);
                check("exception_addr", wb_addr, e.addr);
                check("squash", squash, e.exc != 6'h0);
            end
        end
    end

    task automatic drive_e1(input logic [31:0] pc, input logic [31:0] op,
                            input logic [31:0] val, input logic wr,
                            input logic [31:0] wd, input logic [5:0] exc);
        e1_valid  = 1'b1;
        e1_pc     = pc;
        e1_opcode = op;
        e1_value  = val;
        e1_write  = wr;
        e1_wdata  = wd;
        e1_exc    = exc;
    endtask

    task automatic idle_e1();
        e1_valid = 1'b0;
        e1_pc    = '0;
        e1_opcode = '0;
        e1_value = '0;
        e1_write = 1'b0;
        e1_wdata = '0;
        e1_exc   = '0;
    endtask

    task automatic push(input logic wr, input logic [11:0] wa,
                        input logic [31:0] wd, input logic [5:0] exc,
                        input logic [31:0] pc, input logic [31:0] addr);
        exp_t e;
        e.write = wr;
        e.waddr = wa;
        e.wdata = wd;
        e.exc   = exc;
        e.pc    = pc;
        e.addr  = addr;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 10 && sb.size() != 0; i++)
            @(posedge clk);
        if (sb.size() != 0) begin
            check(name, sb.size(), 0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        drive_e1(v.pc, v.opcode, v.value, v.write, v.wdata, v.exc);
        push(v.exp_write, v.exp_waddr, v.exp_wdata, v.exp_exc, v.exp_pc,
             v.exp_addr);
        @(negedge clk);
        idle_e1();
        lsu_fault = v.lsu;
        lsu_code  = v.lsu_code;
        lsu_addr  = v.lsu_addr;
        take_int  = v.intr;
        @(negedge clk);
        lsu_fault = 1'b0;
        lsu_code  = '0;
        lsu_addr  = '0;
        take_int  = 1'b0;
        drain("vector_timeout");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{32'h100, 32'h34029073, 32'h0, 1'b1, 32'hDEADBEEF, 6'h0,
                     1'b0, 6'h0, 32'h0, 1'b0,
                     1'b1, 12'h340, 32'hDEADBEEF, 6'h0, 32'h0, 32'h0};
        vecs[1]  = '{32'h200, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h0,
                     EXCEPTION_ILLEGAL_INSTRUCTION, 1'b0, 6'h0, 32'h0, 1'b0,
                     1'b0, 12'h0, 32'h0, EXCEPTION_ILLEGAL_INSTRUCTION,
                     32'h200, 32'hFFFFFFFF};
        vecs[2]  = '{32'h210, 32'h00002003, 32'h0, 1'b0, 32'h0, 6'h0,
                     1'b1, 6'd5, 32'h80000003, 1'b1,
                     1'b0, 12'h0, 32'h0, 6'd5, 32'h210, 32'h80000003};
        vecs[3]  = '{32'h300, 32'h30529073, 32'h0, 1'b1, 32'h1234, 6'h0,
                     1'b0, 6'h0, 32'h0, 1'b1,
                     1'b0, 12'h0, 32'h0, EXCEPTION_INTERRUPT, 32'h300, 32'h0};
        vecs[4]  = '{32'h400, 32'h00100073, 32'h00100073, 1'b0, 32'h0,
                     EXCEPTION_BREAKPOINT, 1'b0, 6'h0, 32'h0, 1'b0,
                     1'b0, 12'h0, 32'h0, EXCEPTION_BREAKPOINT, 32'h400,
                     32'h400};
        vecs[5]  = '{32'h500, 32'h00000073, 32'h00000073, 1'b0, 32'h0,
                     EXCEPTION_ECALL, 1'b0, 6'h0, 32'h0, 1'b0,
                     1'b0, 12'h0, 32'h0, EXCEPTION_ECALL, 32'h500, 32'h0};
        vecs[6]  = '{32'h600, 32'h0000100F, 32'h0, 1'b0, 32'h0,
                     EXCEPTION_FENCE, 1'b0, 6'h0, 32'h0, 1'b0,
                     1'b0, 12'h0, 32'h0, EXCEPTION_FENCE, 32'h600, 32'h0};
        vecs[7]  = '{32'h700, 32'h00200073, 32'h0, 1'b0, 32'h0,
                     EXCEPTION_ERET_U, 1'b0, 6'h0, 32'h0, 1'b0,
                     1'b0, 12'h0, 32'h0, EXCEPTION_ERET_U, 32'h700, 32'h0};
        vecs[8]  = '{32'h800, 32'h00000BAD, 32'h00000BAD, 1'b0, 32'h0,
                     EXCEPTION_ILLEGAL_INSTRUCTION, 1'b1, 6'd5, 32'h44, 1'b1,
                     1'b0, 12'h0, 32'h0, EXCEPTION_ILLEGAL_INSTRUCTION,
                     32'h800, 32'h00000BAD};
        vecs[9]  = '{32'h900, 32'h7C029073, 32'h0, 1'b1, 32'h5A5A5A5A, 6'h0,
                     1'b0, 6'h0, 32'h0, 1'b0,
                     1'b1, 12'h7C0, 32'h5A5A5A5A, 6'h0, 32'h0, 32'h0};
        vecs[10] = '{32'h910, 32'h34129073, 32'h0, 1'b1, 32'h77, 6'h0,
                     1'b1, 6'd7, 32'h44, 1'b0,
                     1'b0, 12'h0, 32'h0, 6'd7, 32'h910, 32'h44};

        rst_n     = 1'b0;
        idle_e1();
        lsu_fault = 1'b0;
        lsu_code  = '0;
        lsu_addr  = '0;
        take_int  = 1'b0;
        stall     = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_write", wb_write, 0);
        check("reset_exception", wb_exc, 0);
        check("reset_addr", wb_addr, 0);
        check("reset_inhibit", inhibit, 0);
        check("reset_squash", squash, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 11; i++)
            run_vec(vecs[i]);

        // Trap in WB kills the younger E2 entry and the E1 offer.
        @(negedge clk);
        drive_e1(32'hA00, 32'hFFFFFFFF, 32'h1234ABCD, 1'b0, 32'h0,
                 EXCEPTION_ILLEGAL_INSTRUCTION);
        push(1'b0, 12'h0, 32'h0, EXCEPTION_ILLEGAL_INSTRUCTION, 32'hA00,
             32'h1234ABCD);
        @(negedge clk);
        drive_e1(32'hA04, 32'h34029073, 32'h0, 1'b1, 32'h11111111, 6'h0);
        @(negedge clk);
        check("squash_pulse", squash, 1);
        drive_e1(32'hA08, 32'h34029073, 32'h0, 1'b1, 32'h22222222, 6'h0);
        @(negedge clk);
        idle_e1();
        check("squash_one_cycle", squash, 0);
        repeat (6) @(negedge clk);
        drain("squash_timeout");

        // Stall holds a CSR write in E2 for three cycles.
        @(negedge clk);
        drive_e1(32'hB00, 32'h34129073, 32'h0, 1'b1, 32'h0000CAFE, 6'h0);
        @(negedge clk);
        idle_e1();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_no_write", wb_write, 0);
            check("stall_inhibit", inhibit, 1);
        end
        push(1'b1, 12'h341, 32'h0000CAFE, 6'h0, 32'h0, 32'h0);
        stall = 1'b0;
        drain("stall_timeout");

        // Reset asserted mid-stall discards the held write.
        @(negedge clk);
        drive_e1(32'hC00, 32'h34029073, 32'h0, 1'b1, 32'h33333333, 6'h0);
        @(negedge clk);
        idle_e1();
        stall = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_inhibit", inhibit, 0);
        check("async_reset_write", wb_write, 0);
        check("async_reset_exception", wb_exc, 0);
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        repeat (6) @(negedge clk);
        check("post_reset_inhibit", inhibit, 0);

`ifdef CSR_COMMIT_RETIRE_CNT_EN
        check("retire_count_reset", retire_count, 0);
        for (int i = 0; i < 4; i++)
            run_vec(vecs[0]);
        check("retire_count_four", retire_count, 4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
